// File: rtl/decoder_pkg.sv
// Shared select-code and one-hot vector types for the 2-to-4 decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    SEL_Y1 = 2'b00,
    SEL_Y2 = 2'b01,
    SEL_Y3 = 2'b10,
    SEL_Y4 = 2'b11
  } sel_e;

  // Bit index equals the select code, so bit 0 is y1 and bit 3 is y4.
  typedef logic [3:0] onehot_t;

endpackage

// File: rtl/decoder_2to4_core.sv
// Combinational {en,a,b} to one-hot decode; unknown inputs propagate X through the gates.
module decoder_2to4_core
  import decoder_pkg::*;
(
  input  logic    en,
  input  logic    a,
  input  logic    b,
  output onehot_t y_oh
);

  always_comb begin
    y_oh         = '0;
    y_oh[SEL_Y1] = en & ~a & ~b;
    y_oh[SEL_Y2] = en & ~a &  b;
    y_oh[SEL_Y3] = en &  a & ~b;
    y_oh[SEL_Y4] = en &  a &  b;
  end

endmodule

// File: rtl/decoder_2to4.sv
// Registered (or bypassed) 2-to-4 decoder with optional active-low outputs.
module decoder_2to4
  import decoder_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit REGISTERED = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic y1,
  output logic y2,
  output logic y3,
  output logic y4
);

  onehot_t y_d;
  onehot_t y_q;
  onehot_t y_sel;
  onehot_t y_out;

  decoder_2to4_core u_core (
    .en   (en),
    .a    (a),
    .b    (b),
    .y_oh (y_d)
  );

  always_ff @(posedge clk) begin
    if (rst) y_q <= '0;
    else     y_q <= y_d;
  end

  // Bypass still honours reset so the inactive level holds while rst is high.
  always_comb begin
    y_sel = '0;
    if (REGISTERED)  y_sel = y_q;
    else if (!rst)   y_sel = y_d;
    y_out = y_sel ^ {4{ACTIVE_LOW}};
  end

  assign y1 = y_out[SEL_Y1];
  assign y2 = y_out[SEL_Y2];
  assign y3 = y_out[SEL_Y3];
  assign y4 = y_out[SEL_Y4];

endmodule

// File: tb/tb_decoder_2to4.sv
// Randomized and directed checks of decoder_2to4 in three parameterisations against a select-to-strobe model.
module tb_decoder_2to4;

  logic clk = 1'b0;
  logic rst, en, a, b;
  logic r_y1, r_y2, r_y3, r_y4;
  logic l_y1, l_y2, l_y3, l_y4;
  logic c_y1, c_y2, c_y3, c_y4;

  int unsigned n_compared   = 0;
  int unsigned n_mismatched = 0;
  logic [3:0]  exp_reg;

  always #5 clk = ~clk;

  decoder_2to4 #(.ACTIVE_LOW(1'b0), .REGISTERED(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .y1(r_y1), .y2(r_y2), .y3(r_y3), .y4(r_y4)
  );

  decoder_2to4 #(.ACTIVE_LOW(1'b1), .REGISTERED(1'b1)) dut_al (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .y1(l_y1), .y2(l_y2), .y3(l_y3), .y4(l_y4)
  );

  decoder_2to4 #(.ACTIVE_LOW(1'b0), .REGISTERED(1'b0)) dut_comb (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .y1(c_y1), .y2(c_y2), .y3(c_y3), .y4(c_y4)
  );

  // Expected {y1,y2,y3,y4}: select code n lights the n-th output counting from y1.
  function automatic logic [3:0] model(input logic e, input logic sa, input logic sb);
    int unsigned sel;
    sel = {sa, sb};
    return e ? (4'b1000 >> sel) : 4'b0000;
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs, clock one edge, then compare all three instances.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic sa, input logic sb);
    logic [3:0] now_exp;
    rst = r; en = e; a = sa; b = sb;
    now_exp = r ? 4'b0000 : model(e, sa, sb);
    @(posedge clk);
    exp_reg = now_exp;
    #1;
    check({tag, "/reg"}, {r_y1, r_y2, r_y3, r_y4}, exp_reg);
    check({tag, "/al"},  {l_y1, l_y2, l_y3, l_y4}, ~exp_reg);
    check({tag, "/comb"},{c_y1, c_y2, c_y3, c_y4}, now_exp);
  endtask

  initial begin
    logic [3:0] got;
    rst = 1'b1; en = 1'b1; a = 1'b1; b = 1'b1;
    exp_reg = 4'b0000;

    // Reset held two cycles with an active select on the inputs.
    step("rst0", 1'b1, 1'b1, 1'b1, 1'b1);
    step("rst1", 1'b1, 1'b1, 1'b1, 1'b1);
    step("rst_rel", 1'b0, 1'b1, 1'b1, 1'b1);
    check("rst_rel_y4", {r_y1, r_y2, r_y3, r_y4}, 4'b0001);

    // Exhaustive select sweep.
    for (int unsigned s = 0; s < 4; s++) begin
      logic [1:0] code;
      code = s[1:0];
      step("sweep", 1'b0, 1'b1, code[1], code[0]);
    end

    // Enable gating on select 10.
    step("en_on",  1'b0, 1'b1, 1'b1, 1'b0);
    step("en_off", 1'b0, 1'b0, 1'b1, 1'b0);
    check("en_off_al", {l_y1, l_y2, l_y3, l_y4}, 4'b1111);
    step("en_on2", 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset mid-operation with y2 active.
    step("mid_y2",  1'b0, 1'b1, 1'b0, 1'b1);
    step("mid_rst", 1'b1, 1'b1, 1'b0, 1'b1);
    step("mid_rel", 1'b0, 1'b1, 1'b0, 1'b1);

    // Mid-cycle input changes must not disturb registered outputs.
    for (int unsigned i = 0; i < 8; i++) begin
      #($urandom_range(1, 3));
      en = $urandom_range(0, 1); a = $urandom_range(0, 1); b = $urandom_range(0, 1);
      #1;
      check("hold_reg", {r_y1, r_y2, r_y3, r_y4}, exp_reg);
      check("hold_comb", {c_y1, c_y2, c_y3, c_y4}, model(en, a, b));
      @(posedge clk); #1;
      exp_reg = model(en, a, b);
      check("hold_next", {r_y1, r_y2, r_y3, r_y4}, exp_reg);
    end

    // Randomized traffic with occasional reset.
    for (int unsigned i = 0; i < 200; i++) begin
      step("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Bypass instance: input changes asynchronous to clk, en high.
    rst = 1'b0; en = 1'b1;
    for (int unsigned i = 0; i < 40; i++) begin
      #($urandom_range(1, 23));
      a = $urandom_range(0, 1); b = $urandom_range(0, 1);
      #1;
      got = {c_y1, c_y2, c_y3, c_y4};
      check("async_comb", got, model(1'b1, a, b));
      check("async_onehot", 4'($countones(got)), 4'd1);
    end

    // Bypass instance forced inactive while rst is high.
    @(negedge clk);
    rst = 1'b1; a = 1'b0; b = 1'b0; en = 1'b1;
    #1;
    check("comb_rst", {c_y1, c_y2, c_y3, c_y4}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("comb_rel", {c_y1, c_y2, c_y3, c_y4}, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
